// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// Module  : rf_scoreboard
// Brief   : Per-register pending-write counters driving RAW/saturation issue stall.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module rf_scoreboard #(
  parameter  int NUM_REGS = 32,
  parameter  int MAX_PEND = 3,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                iss_valid,
  input  logic                iss_we,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic                iss_rs1_used,
  input  logic [ADDR_W-1:0]   iss_rs1,
  input  logic                iss_rs2_used,
  input  logic [ADDR_W-1:0]   iss_rs2,
  output logic                iss_stall,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err
);

  localparam logic [CNT_W-1:0] c_max_pend = CNT_W'(MAX_PEND);

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_at_max;
  logic [NUM_REGS-1:0] w_err_hit;
  logic [NUM_REGS-1:0] w_rs1_hit;
  logic [NUM_REGS-1:0] w_rs2_hit;
  logic [NUM_REGS-1:0] w_sat_hit;
  logic                w_haz_rs1;
  logic                w_haz_rs2;
  logic                w_sat;
  logic                w_iss_go;
  logic                r_err;

  // Hazards look only at registered counts; a same-cycle writeback never bypasses.
  assign w_haz_rs1 = iss_rs1_used & (|w_rs1_hit);
  assign w_haz_rs2 = iss_rs2_used & (|w_rs2_hit);
  assign w_sat     = iss_we & (|w_sat_hit);
  assign iss_stall = iss_valid & (w_haz_rs1 | w_haz_rs2 | w_sat);
  assign w_iss_go  = iss_valid & ~iss_stall & iss_we;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(i);

    assign w_rs1_hit[i] = w_busy[i] & (iss_rs1 == c_idx);
    assign w_rs2_hit[i] = w_busy[i] & (iss_rs2 == c_idx);
    assign w_sat_hit[i] = w_at_max[i] & (iss_rd == c_idx);

    if (ZERO_REG != 0 && i == 0) begin : g_untracked
      assign w_busy[i]    = 1'b0;
      assign w_at_max[i]  = 1'b0;
      assign w_err_hit[i] = 1'b0;
    end else begin : g_tracked
      logic [CNT_W-1:0] r_cnt;
      logic             w_inc;
      logic             w_dec;

      assign w_inc = w_iss_go & (iss_rd == c_idx);
      assign w_dec = wb_valid & (wb_rd == c_idx);

      // Simultaneous issue and writeback on one register cancel out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (flush) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dec && !w_inc && (r_cnt != '0)) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end

      assign w_busy[i]    = (r_cnt != '0);
      assign w_at_max[i]  = (r_cnt == c_max_pend);
      assign w_err_hit[i] = w_dec & ~w_inc & (r_cnt == '0);
    end
  end

  // Underflow is sticky and independent of a concurrent flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (|w_err_hit) begin
      r_err <= 1'b1;
    end
  end

  assign busy_vec = w_busy;
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rf_scoreboard.sv
// ----------------------------------------------------------------------------
// Module  : tb_rf_scoreboard
// Brief   : Random and directed stimulus against a counting model of the scoreboard.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rf_scoreboard;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int MP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          iss_valid = 1'b0;
  logic          iss_we = 1'b0;
  logic [AW-1:0] iss_rd = '0;
  logic          iss_rs1_used = 1'b0;
  logic [AW-1:0] iss_rs1 = '0;
  logic          iss_rs2_used = 1'b0;
  logic [AW-1:0] iss_rs2 = '0;
  logic          iss_stall;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [NR-1:0] busy_vec;
  logic          err;

  int errors = 0;
  int checks = 0;

  int m_cnt [NR];
  bit m_err;

  rf_scoreboard #(.NUM_REGS(NR), .MAX_PEND(MP), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd),
    .iss_rs1_used(iss_rs1_used), .iss_rs1(iss_rs1),
    .iss_rs2_used(iss_rs2_used), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy_vec(busy_vec), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit tracked(input int r);
    return r != 0;
  endfunction

  function automatic bit model_stall();
    bit h1, h2, sat;
    h1  = iss_rs1_used && m_cnt[iss_rs1] > 0;
    h2  = iss_rs2_used && m_cnt[iss_rs2] > 0;
    sat = iss_we && tracked(iss_rd) && m_cnt[iss_rd] == MP;
    return iss_valid && (h1 || h2 || sat);
  endfunction

  // Compare against the model mid-cycle, then advance the model to the next edge.
  always @(negedge clk) begin
    logic [NR-1:0] exp_busy;
    bit exp_stall, inc, dec, same;
    if (!rst_n) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_err = 0;
    end
    exp_busy = '0;
    for (int k = 0; k < NR; k++) exp_busy[k] = (m_cnt[k] > 0);
    exp_stall = model_stall();
    check("busy_vec", 64'(busy_vec), 64'(exp_busy));
    check("err", 64'(err), 64'(m_err));
    check("iss_stall", 64'(iss_stall), 64'(exp_stall));
    if (rst_n) begin
      inc  = iss_valid && !exp_stall && iss_we && tracked(iss_rd);
      dec  = wb_valid && tracked(wb_rd);
      same = inc && dec && (iss_rd == wb_rd);
      if (dec && !same && m_cnt[wb_rd] == 0) m_err = 1;
      if (flush) begin
        foreach (m_cnt[k]) m_cnt[k] = 0;
      end else if (!same) begin
        if (inc) m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
        if (dec && m_cnt[wb_rd] > 0) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
      end
    end
  end

  task automatic set_in(input logic v, input logic we, input int rd,
                        input logic u1, input int s1, input logic u2, input int s2,
                        input logic wv, input int wr, input logic fl);
    iss_valid = v; iss_we = we; iss_rd = AW'(rd);
    iss_rs1_used = u1; iss_rs1 = AW'(s1);
    iss_rs2_used = u2; iss_rs2 = AW'(s2);
    wb_valid = wv; wb_rd = AW'(wr); flush = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_err = 0;
    idle();
    tick(); tick();
    check("reset_busy", 64'(busy_vec), 64'h0);
    check("reset_err", 64'(err), 64'h0);
    #4 rst_n = 1'b1;
    tick();

    // Issue rd=5 -> busy bit 5 next cycle.
    set_in(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); tick();
    idle(); #1;
    check("t1_busy", 64'(busy_vec), 64'h20);
    check("t1_stall", 64'(iss_stall), 64'h0);

    // RAW on rs1=5, released the cycle after writeback.
    set_in(1, 0, 0, 1, 5, 0, 0, 0, 0, 0); #1;
    check("t2_raw", 64'(iss_stall), 64'h1);
    set_in(1, 0, 0, 1, 5, 0, 0, 1, 5, 0); #1;
    check("t2_wb_same", 64'(iss_stall), 64'h1);
    tick();
    check("t2_released", 64'(iss_stall), 64'h0);
    idle(); tick();

    // Register 0 is never tracked.
    set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    idle(); #1;
    check("t3_busy0", 64'(busy_vec), 64'h0);
    set_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); #1;
    check("t3_rs1_0", 64'(iss_stall), 64'h0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    idle(); #1;
    check("t3_err0", 64'(err), 64'h0);

    // Saturation on rd=7, then net-zero issue+wb.
    repeat (3) begin set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); tick(); end
    set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t4_sat", 64'(iss_stall), 64'h1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); tick();
    set_in(1, 1, 7, 0, 0, 0, 0, 1, 7, 0); #1;
    check("t4_nosat_at2", 64'(iss_stall), 64'h0);
    tick();
    set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(1, 1, 7, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t4_sat_again", 64'(iss_stall), 64'h1);
    repeat (3) begin set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); tick(); end
    idle(); #1;
    check("t4_drained", 64'(busy_vec), 64'h0);

    // Underflow on rd=9 is sticky.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); tick();
    idle(); #1;
    check("t5_err", 64'(err), 64'h1);
    check("t5_busy", 64'(busy_vec), 64'h0);
    tick(); tick();
    check("t5_sticky", 64'(err), 64'h1);

    // Flush beats a simultaneous issue.
    set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(1, 1, 4, 0, 0, 0, 0, 0, 0, 0); tick();
    idle(); #1;
    check("t6_pending", 64'(busy_vec), 64'h18);
    set_in(1, 1, 6, 0, 0, 0, 0, 0, 0, 1); tick();
    idle(); #1;
    check("t6_flushed", 64'(busy_vec), 64'h0);

    // Mid-cycle async reset.
    set_in(1, 1, 10, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(1, 0, 0, 1, 10, 0, 0, 0, 0, 0); #1;
    check("t6_pre_rst", 64'(iss_stall), 64'h1);
    rst_n = 1'b0; #1;
    check("t6_async_busy", 64'(busy_vec), 64'h0);
    check("t6_async_err", 64'(err), 64'h0);
    check("t6_async_stall", 64'(iss_stall), 64'h0);
    tick();
    rst_n = 1'b1;
    idle(); tick();

    // Random traffic over a narrow register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70, $urandom_range(0, 9),
             $urandom_range(0, 1), $urandom_range(0, 9),
             $urandom_range(0, 1), $urandom_range(0, 9),
             $urandom_range(0, 99) < 45, $urandom_range(0, 9),
             $urandom_range(0, 99) < 2);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
